// File: rtl/button_step_arbiter.sv
// button_step_arbiter: turns the two raw DE10-Lite push-buttons (KEY[0] = up,
// KEY[1] = down, active-low) into single count-step requests for the counter.
// Each key is synchronised and debounced, and a press becomes a one-cycle event.
// Each event sets a one-deep pending flag for its direction. An output slot then
// presents one step at a time over a valid/ready handshake.
// Optional auto-repeat while a key is held: define BUTTON_AUTOREPEAT_EN.
module button_step_arbiter #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       MAX10_CLK1_50,
    input  logic       RESET_N,
    input  logic [1:0] KEY,
    input  logic       step_ready,
    output logic       step_valid,
    output logic       step_up,
    output logic [7:0] drop_cnt
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    // Refuse configurations that the counters below cannot represent.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("button_step_arbiter: cycle parameters must be at least 1");
    end

    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_d;
    logic [DW-1:0] deb_cnt [2];
    logic [1:0]    press;
    logic [1:0]    rpt_fire;

    logic       inc_pend;
    logic       dec_pend;
    logic       last_up;
    logic       inc_ev;
    logic       dec_ev;
    logic       slot_free;
    logic       load;
    logic       tie;
    logic       grant_up;
    logic       take_inc;
    logic       take_dec;
    logic       drop_inc;
    logic       drop_dec;
    logic [1:0] drop_add;
    logic [8:0] drop_sum;
    logic [7:0] drop_next;

    // Two-flop synchroniser per key; released (1) is the safe reset level.
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
        end
    end

    // Debouncer: accept a new level only after DEBOUNCE_CYCLES straight mismatches.
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            deb   <= 2'b11;
            deb_d <= 2'b11;
            for (int k = 0; k < 2; k++) begin
                deb_cnt[k] <= '0;
            end
        end else begin
            deb_d <= deb;
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] == deb[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_LAST) begin
                    deb[k]     <= sync2[k];
                    deb_cnt[k] <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + DW'(1);
                end
            end
        end
    end

    // Press pulse: debounced level has just gone from released to pressed.
    always_comb begin
        press = deb_d & ~deb;
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    rpt_state_t    rpt_state [2];
    logic [RW-1:0] rpt_cnt   [2];

    // Repeat event on the last cycle of the delay or of each period, only while still held.
    always_comb begin
        rpt_fire = 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (!deb[k]) begin
                case (rpt_state[k])
                    RPT_DELAY:  rpt_fire[k] = (rpt_cnt[k] == RD_LAST);
                    RPT_REPEAT: rpt_fire[k] = (rpt_cnt[k] == RP_LAST);
                    default:    rpt_fire[k] = 1'b0;
                endcase
            end else begin
                rpt_fire[k] = 1'b0;
            end
        end
    end

    // Per-key repeat FSM; a debounced release returns it to idle silently.
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int k = 0; k < 2; k++) begin
                rpt_state[k] <= RPT_IDLE;
                rpt_cnt[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (deb[k]) begin
                    rpt_state[k] <= RPT_IDLE;
                    rpt_cnt[k]   <= '0;
                end else begin
                    case (rpt_state[k])
                        RPT_IDLE: begin
                            if (press[k]) begin
                                rpt_state[k] <= RPT_DELAY;
                            end else begin
                                rpt_state[k] <= RPT_IDLE;
                            end
                            rpt_cnt[k] <= '0;
                        end
                        RPT_DELAY: begin
                            if (rpt_cnt[k] == RD_LAST) begin
                                rpt_state[k] <= RPT_REPEAT;
                                rpt_cnt[k]   <= '0;
                            end else begin
                                rpt_cnt[k] <= rpt_cnt[k] + RW'(1);
                            end
                        end
                        RPT_REPEAT: begin
                            if (rpt_cnt[k] == RP_LAST) begin
                                rpt_cnt[k] <= '0;
                            end else begin
                                rpt_cnt[k] <= rpt_cnt[k] + RW'(1);
                            end
                        end
                        default: begin
                            rpt_state[k] <= RPT_IDLE;
                            rpt_cnt[k]   <= '0;
                        end
                    endcase
                end
            end
        end
    end
`else
    // Without auto-repeat only the press itself produces an event.
    always_comb begin
        rpt_fire = 2'b00;
    end
`endif

    // Arbitration: a tie goes opposite to the previous tie winner; drops count events hitting a full flag.
    always_comb begin
        inc_ev    = press[0] | rpt_fire[0];
        dec_ev    = press[1] | rpt_fire[1];
        slot_free = ~step_valid | step_ready;
        load      = slot_free & (inc_pend | dec_pend);
        tie       = inc_pend & dec_pend;
        grant_up  = tie ? ~last_up : inc_pend;
        take_inc  = load & grant_up;
        take_dec  = load & ~grant_up;
        drop_inc  = inc_ev & inc_pend & ~take_inc;
        drop_dec  = dec_ev & dec_pend & ~take_dec;
        drop_add  = {1'b0, drop_inc} + {1'b0, drop_dec};
        drop_sum  = {1'b0, drop_cnt} + {7'd0, drop_add};
        if (drop_sum[8]) begin
            drop_next = 8'd255;
        end else begin
            drop_next = drop_sum[7:0];
        end
    end

    // Pending flags, output slot, tie memory and drop counter.
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            inc_pend   <= 1'b0;
            dec_pend   <= 1'b0;
            step_valid <= 1'b0;
            step_up    <= 1'b0;
            last_up    <= 1'b0;
            drop_cnt   <= 8'd0;
        end else begin
            inc_pend <= (inc_pend & ~take_inc) | inc_ev;
            dec_pend <= (dec_pend & ~take_dec) | dec_ev;
            if (load) begin
                step_valid <= 1'b1;
                step_up    <= grant_up;
            end else if (slot_free) begin
                step_valid <= 1'b0;
            end else begin
                step_valid <= step_valid;
            end
            if (load && tie) begin
                last_up <= grant_up;
            end else begin
                last_up <= last_up;
            end
            drop_cnt <= drop_next;
        end
    end

endmodule

// File: tb/tb_button_step_arbiter.sv
// Self-checking bench for button_step_arbiter: directed tables and sequences
// plus random key/ready activity compared every cycle with a reference model
// built from key-sample history and hold ages.
module tb_button_step_arbiter;

    localparam int DEB  = 4;
    localparam int RD   = 20;
    localparam int RP   = 8;
    localparam int HOLD = 60;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] key = 2'b11;
    logic       ready = 1'b1;
    logic       step_valid;
    logic       step_up;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [1:0] hist[$];
    logic [1:0] m_deb;
    logic [1:0] m_deb_old;
    int         m_age [2];
    logic [1:0] m_pend;
    logic       m_valid;
    logic       m_up;
    logic       m_last;
    int         m_drop;

    typedef struct packed {
        logic [1:0] key;
        logic       ready;
        logic       exp_valid;
        logic       exp_up;
    } vec_t;
    vec_t vecs [32];

    button_step_arbiter #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .MAX10_CLK1_50(clk),
        .RESET_N(rst_n),
        .KEY(key),
        .step_ready(ready),
        .step_valid(step_valid),
        .step_up(step_up),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DEB + 2; i++) hist.push_front(2'b11);
        m_deb     = 2'b11;
        m_deb_old = 2'b11;
        m_age[0]  = -1;
        m_age[1]  = -1;
        m_pend    = 2'b00;
        m_valid   = 1'b0;
        m_up      = 1'b0;
        m_last    = 1'b0;
        m_drop    = 0;
    endtask

    // One rising edge of the reference model, from the inputs seen at that edge.
    task automatic model_edge();
        logic [1:0] ev;
        logic [1:0] new_deb;
        int         dir;
        bit         all_diff;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                ev[k] = (m_deb_old[k] && !m_deb[k]) ||
                        (AUTO && !m_deb[k] && m_age[k] >= RD && ((m_age[k] - RD) % RP) == 0);
            end
            if (!m_valid || ready) begin
                if (m_pend[0] && m_pend[1]) begin
                    dir    = m_last ? 0 : 1;
                    m_last = (dir == 1);
                end else if (m_pend[0]) begin
                    dir = 1;
                end else if (m_pend[1]) begin
                    dir = 0;
                end else begin
                    dir = -1;
                end
                if (dir < 0) begin
                    m_valid = 1'b0;
                end else begin
                    m_valid = 1'b1;
                    m_up    = (dir == 1);
                    if (dir == 1) m_pend[0] = 1'b0;
                    else          m_pend[1] = 1'b0;
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (ev[k]) begin
                    if (m_pend[k]) begin
                        if (m_drop < 255) m_drop++;
                    end else begin
                        m_pend[k] = 1'b1;
                    end
                end
            end
            // debounced level follows the raw key once it has differed for DEB
            // consecutive samples, seen two edges late through the synchroniser
            hist.push_front(key);
            new_deb = m_deb;
            for (int k = 0; k < 2; k++) begin
                all_diff = 1'b1;
                for (int j = 2; j < DEB + 2; j++) begin
                    if (hist[j][k] == m_deb[k]) all_diff = 1'b0;
                end
                if (all_diff) new_deb[k] = ~m_deb[k];
            end
            while (hist.size() > DEB + 2) void'(hist.pop_back());
            for (int k = 0; k < 2; k++) begin
                m_age[k] = new_deb[k] ? -1 : (m_deb[k] ? 0 : m_age[k] + 1);
            end
            m_deb_old = m_deb;
            m_deb     = new_deb;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("model_valid", 32'(step_valid), 32'(m_valid));
        chk("model_up", 32'(step_up), 32'(m_up));
        chk("model_drop", 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic press(input logic [1:0] mask, input int low, input int high);
        key = key & ~mask;
        repeat (low) cycle();
        key = key | mask;
        repeat (high) cycle();
    endtask

    initial begin
        int t_steps[$];
        int exp_off[$];
        int hold0;
        int hold1;

        model_reset();

        // table: KEY[0] pressed 10 cycles, released, then a 2-cycle KEY[1] glitch
        for (int i = 0; i < 32; i++) begin
            vecs[i].key       = (i < 10) ? 2'b10 : ((i == 20 || i == 21) ? 2'b01 : 2'b11);
            vecs[i].ready     = 1'b1;
            vecs[i].exp_valid = (i == DEB + 3);
            vecs[i].exp_up    = (i >= DEB + 3);
        end

        // reset held with keys toggling
        rst_n = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            key = 2'($urandom);
            cycle();
            chk("rst_valid", 32'(step_valid), 32'd0);
            chk("rst_drop", 32'(drop_cnt), 32'd0);
        end
        key   = 2'b11;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("idle_valid", 32'(step_valid), 32'd0);
        end

        // table-driven press latency, release and glitch
        for (int i = 0; i < 32; i++) begin
            key   = vecs[i].key;
            ready = vecs[i].ready;
            cycle();
            chk("vec_valid", 32'(step_valid), 32'(vecs[i].exp_valid));
            chk("vec_up", 32'(step_up), 32'(vecs[i].exp_up));
        end
        key = 2'b11;
        repeat (5) cycle();

        // KEY[1] held HOLD cycles: press step plus auto-repeat steps
        ready = 1'b1;
        key   = 2'b01;
        for (int i = 0; i < HOLD + 30; i++) begin
            if (i == HOLD) key = 2'b11;
            cycle();
            if (step_valid && !step_up) t_steps.push_back(i);
        end
        exp_off.push_back(0);
        if (AUTO) begin
            for (int t = RD; t < HOLD; t += RP) exp_off.push_back(t);
        end
        chk("rpt_count", 32'(t_steps.size()), 32'(exp_off.size()));
        if (t_steps.size() > 0) chk("rpt_first", 32'(t_steps[0]), 32'(DEB + 3));
        for (int j = 0; j < t_steps.size() && j < exp_off.size(); j++) begin
            chk("rpt_offset", 32'(t_steps[j] - t_steps[0]), 32'(exp_off[j]));
        end

        // back-pressure: three presses, one dropped
        ready = 1'b0;
        repeat (3) press(2'b01, 8, 8);
        chk("bp_valid", 32'(step_valid), 32'd1);
        chk("bp_up", 32'(step_up), 32'd1);
        chk("bp_drop", 32'(drop_cnt), 32'd1);
        ready = 1'b1;
        cycle();
        chk("bp_second_valid", 32'(step_valid), 32'd1);
        chk("bp_second_up", 32'(step_up), 32'd1);
        cycle();
        chk("bp_empty", 32'(step_valid), 32'd0);

        // ties alternate: first up then down, next down then up
        ready = 1'b0;
        press(2'b11, 8, 8);
        chk("tie1_up", 32'(step_up), 32'd1);
        ready = 1'b1;
        cycle();
        chk("tie1_second_valid", 32'(step_valid), 32'd1);
        chk("tie1_second_up", 32'(step_up), 32'd0);
        cycle();
        chk("tie1_empty", 32'(step_valid), 32'd0);
        ready = 1'b0;
        press(2'b11, 8, 8);
        chk("tie2_valid", 32'(step_valid), 32'd1);
        chk("tie2_up", 32'(step_up), 32'd0);
        ready = 1'b1;
        cycle();
        chk("tie2_second_up", 32'(step_up), 32'd1);
        cycle();
        chk("tie2_empty", 32'(step_valid), 32'd0);

        // reset while a step is presented and another is pending
        ready = 1'b0;
        repeat (2) press(2'b01, 8, 8);
        chk("mid_valid", 32'(step_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(step_valid), 32'd0);
        chk("mid_rst_up", 32'(step_up), 32'd0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
        repeat (3) cycle();
        rst_n = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("post_rst_valid", 32'(step_valid), 32'd0);
        end

        // drop counter saturation with double drops
        ready = 1'b0;
        for (int i = 0; i < 135; i++) press(2'b11, 6, 6);
        chk("drop_sat", 32'(drop_cnt), 32'd255);
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        ready = 1'b1;

        // random key activity and back-pressure against the model
        hold0 = 0;
        hold1 = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold0 == 0) begin
                key[0] = ~key[0];
                hold0  = $urandom_range(1, 30);
            end else begin
                hold0--;
            end
            if (hold1 == 0) begin
                key[1] = ~key[1];
                hold1  = $urandom_range(1, 30);
            end else begin
                hold1--;
            end
            ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
